// File: rtl/mem_req_arbiter_if.sv
// ============================================================================
// mem_req_arbiter_if : fetch/data request ports and single-outstanding bridge
//                      port bundled for mem_req_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mem_req_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  i_valid;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] i_rdata;

  logic                  d_valid;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_ready;
  logic [DATA_WIDTH-1:0] d_rdata;

  logic                  m_valid;
  logic                  m_write;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_rdata;

  logic [1:0]            grant;
  logic                  busy;

  // Arbiter side: serves the CPU ports and masters the bridge.
  modport master (
    input  i_valid, i_addr, d_valid, d_write, d_addr, d_wdata, m_ready, m_rdata,
    output i_ready, i_rdata, d_ready, d_rdata,
           m_valid, m_write, m_addr, m_wdata, grant, busy
  );

  modport slave (
    output i_valid, i_addr, d_valid, d_write, d_addr, d_wdata, m_ready, m_rdata,
    input  i_ready, i_rdata, d_ready, d_rdata,
           m_valid, m_write, m_addr, m_wdata, grant, busy
  );
endinterface

`default_nettype wire

// File: rtl/mem_req_arbiter.sv
// ============================================================================
// mem_req_arbiter : two-port (fetch/data) arbiter onto one AXI-lite bridge,
//                   one transaction outstanding. Define ARB_RR_EN for
//                   round-robin arbitration; default is data-first priority.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_req_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  wire logic          clk,
  input  wire logic          rstn,
  mem_req_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_m_valid;
  logic                  r_m_write;
  logic [ADDR_WIDTH-1:0] r_m_addr;
  logic [DATA_WIDTH-1:0] r_m_wdata;
  logic                  r_i_ready;
  logic                  r_d_ready;
  logic [DATA_WIDTH-1:0] r_i_rdata;
  logic [DATA_WIDTH-1:0] r_d_rdata;
  logic [1:0]            r_grant;
  logic                  r_busy;

  logic                  w_pick_i;
  logic                  w_pick_d;

`ifdef ARB_RR_EN
  // Set when the data port owned the previous transaction.
  logic                  r_last_data;
  assign w_pick_d = bus.d_valid & (~bus.i_valid | ~r_last_data);
`else
  assign w_pick_d = bus.d_valid;
`endif
  assign w_pick_i = bus.i_valid & ~w_pick_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_m_valid   <= 1'b0;
      r_m_write   <= 1'b0;
      r_m_addr    <= '0;
      r_m_wdata   <= '0;
      r_i_ready   <= 1'b0;
      r_d_ready   <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_grant     <= 2'b00;
      r_busy      <= 1'b0;
`ifdef ARB_RR_EN
      r_last_data <= 1'b1;
`endif
    end else begin
      r_m_valid <= 1'b0;
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pick_i || w_pick_d) begin
            r_grant   <= {w_pick_d, w_pick_i};
            r_m_write <= w_pick_d & bus.d_write;
            r_m_addr  <= w_pick_d ? bus.d_addr : bus.i_addr;
            r_m_wdata <= w_pick_d ? bus.d_wdata : '0;
            r_m_valid <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          if (bus.m_ready) begin
            if (r_grant[0]) begin
              r_i_rdata <= bus.m_rdata;
              r_i_ready <= 1'b1;
            end else begin
              if (!r_m_write) r_d_rdata <= bus.m_rdata;
              r_d_ready <= 1'b1;
            end
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_grant <= 2'b00;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
`ifdef ARB_RR_EN
          r_last_data <= r_grant[1];
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.m_valid = r_m_valid;
  assign bus.m_write = r_m_write;
  assign bus.m_addr  = r_m_addr;
  assign bus.m_wdata = r_m_wdata;
  assign bus.i_ready = r_i_ready;
  assign bus.d_ready = r_d_ready;
  assign bus.i_rdata = r_i_rdata;
  assign bus.d_rdata = r_d_rdata;
  assign bus.grant   = r_grant;
  assign bus.busy    = r_busy;

endmodule

`default_nettype wire
